// File: rtl/stove_button_conditioner_pkg.sv
// Shared definitions for the stove push-button front end: channel indices,
// default repeat mask, channel FSM states and counter-width helpers.
package stove_button_conditioner_pkg;

    localparam int unsigned BTN_POWER  = 0;
    localparam int unsigned BTN_SURF_A = 1;
    localparam int unsigned BTN_SURF_B = 2;
    localparam int unsigned BTN_INC    = 3;
    localparam int unsigned BTN_DEC    = 4;
    localparam int unsigned BTN_COUNT  = 5;

    localparam logic [BTN_COUNT-1:0] BTN_REPEAT_DEFAULT = 5'b11000;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_HELD,
        ST_REPEATING
    } btn_state_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counters compare against n-1, so $clog2(n) bits suffice; never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchronizer, debounce filter and press/auto-repeat FSM
// producing a registered single-cycle pulse and a debounced level.
module button_channel
    import stove_button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RAW_ACTIVE_LOW  = 1'b1,
    parameter logic        REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic async_reset,
    input  logic i_raw,
    output logic o_pulse,
    output logic o_level
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RP_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    logic            r_meta;
    logic            r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic [RP_W-1:0] r_rcnt;
    logic            r_pulse;
    btn_state_t      r_state;

    logic w_sync;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    assign w_sync = r_sync ^ RAW_ACTIVE_LOW;
    assign w_flip = (w_sync != r_level) && (r_db_cnt == DB_LAST);
    assign w_rise = w_flip && !r_level;
    assign w_fall = w_flip && r_level;

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_meta <= RAW_ACTIVE_LOW;
            r_sync <= RAW_ACTIVE_LOW;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (w_sync == r_level) begin
            r_db_cnt <= '0;
        end else if (w_flip) begin
            r_db_cnt <= '0;
            r_level  <= ~r_level;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Edges are taken from the debounce flip condition, so the press pulse
    // lands in the same cycle that o_level first reads high.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_state <= ST_RELEASED;
            r_rcnt  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_fall) begin
                r_state <= ST_RELEASED;
                r_rcnt  <= '0;
            end else begin
                case (r_state)
                    ST_RELEASED: begin
                        r_rcnt <= '0;
                        if (w_rise) begin
                            r_state <= ST_HELD;
                            r_pulse <= 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (REPEAT_EN) begin
                            if (r_rcnt == DELAY_LAST) begin
                                r_state <= ST_REPEATING;
                                r_pulse <= 1'b1;
                                r_rcnt  <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + 1'b1;
                            end
                        end
                    end
                    ST_REPEATING: begin
                        if (r_rcnt == PERIOD_LAST) begin
                            r_pulse <= 1'b1;
                            r_rcnt  <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_RELEASED;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;

endmodule

// File: rtl/stove_button_conditioner.sv
// Conditions the raw DE0 push-buttons into clean single-cycle command pulses
// and debounced levels, one independent button_channel per button.
module stove_button_conditioner
    import stove_button_conditioner_pkg::*;
#(
    parameter int unsigned          N_BUTTONS       = BTN_COUNT,
    parameter int unsigned          DEBOUNCE_CYCLES = 500000,
    parameter logic                 RAW_ACTIVE_LOW  = 1'b1,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = N_BUTTONS'(BTN_REPEAT_DEFAULT),
    parameter int unsigned          REPEAT_DELAY    = 25000000,
    parameter int unsigned          REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 async_reset,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_pulse,
    output logic [N_BUTTONS-1:0] btn_level
);

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW),
            .REPEAT_EN       (REPEAT_MASK[g]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .async_reset (async_reset),
            .i_raw       (btn_raw[g]),
            .o_pulse     (btn_pulse[g]),
            .o_level     (btn_level[g])
        );
    end

endmodule
